// File: rtl/uart_sched_pkg.sv
// Shared types and ASCII constants for the UART
// result scheduler.
package uart_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND_ID,
    SEND_COLON,
    SEND_BITS,
    SEND_CR,
    SEND_LF
  } state_e;

  localparam logic [7:0] CHAR_ZERO  = 8'h30;
  localparam logic [7:0] CHAR_ONE   = 8'h31;
  localparam logic [7:0] CHAR_COLON = 8'h3A;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_LF    = 8'h0A;

  function automatic logic [7:0] hex_digit(
    input logic [3:0] d
  );
    if (d < 4'd10) begin
      return 8'h30 + {4'h0, d};
    end
    return 8'h37 + {4'h0, d};
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Round-robin arbiter: the search starts at ptr
// and wraps from N-1 back to 0.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  logic [IW-1:0] j;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    j       = ptr;
    for (int i = 0; i < N; i++) begin
      if (!any && req[j]) begin
        any     = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = j;
      end
      j = (j == IW'(N - 1)) ? '0 : j + IW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin serializer of N result words into
// ASCII text lines for a shared uart_tx6 FIFO.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int N = 4,
  parameter int M = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N*M-1:0] data_in,
  output logic [N-1:0]   ack,
  output logic           busy,
  output logic [7:0]     uart_data_out,
  output logic           uart_buffer_write,
  input  logic           uart_buffer_full
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (M > 1) ? $clog2(M) : 1;

  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [M-1:0]  shift_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    ch_q;
  logic [N-1:0]  ack_q;
  logic          busy_q;
  logic          wr_q;
  logic [7:0]    dout_q, char_d;

  logic [N-1:0]  gnt;
  logic [IW-1:0] gidx;
  logic          any;
  logic [M-1:0]  sel_word;
  logic          emit;
  logic          lf_done;

  rr_arbiter #(.N(N), .IW(IW)) u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gidx),
    .any     (any)
  );

  always_comb begin
    sel_word = '0;
    for (int k = 0; k < N; k++) begin
      if (gnt[k]) sel_word = data_in[k*M +: M];
    end
  end

  assign ptr_d = (gidx == IW'(N - 1)) ? '0 : gidx + IW'(1);

  // Skipping the cycle after a write covers the
  // one-cycle lag of buffer_full.
  assign emit    = !uart_buffer_full && !wr_q;
  assign lf_done = wr_q && (dout_q == CHAR_LF);

  always_comb begin
    char_d  = dout_q;
    state_d = state_q;
    unique case (state_q)
      SEND_ID: begin
        char_d  = hex_digit(ch_q);
        state_d = SEND_COLON;
      end
      SEND_COLON: begin
        char_d  = CHAR_COLON;
        state_d = SEND_BITS;
      end
      SEND_BITS: begin
        char_d  = shift_q[cnt_q] ? CHAR_ONE : CHAR_ZERO;
        state_d = (cnt_q == '0) ? SEND_CR : SEND_BITS;
      end
      SEND_CR: begin
        char_d  = CHAR_CR;
        state_d = SEND_LF;
      end
      SEND_LF: begin
        char_d  = CHAR_LF;
        state_d = SEND_LF;
      end
      default: begin
        char_d  = dout_q;
        state_d = state_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      ch_q    <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      wr_q    <= 1'b0;
      dout_q  <= 8'h00;
    end else begin
      ack_q <= '0;
      unique case (state_q)
        IDLE: begin
          wr_q <= 1'b0;
          if (any) begin
            shift_q <= sel_word;
            ack_q   <= gnt;
            ptr_q   <= ptr_d;
            ch_q    <= 4'(gidx);
            cnt_q   <= CW'(M - 1);
            busy_q  <= 1'b1;
            state_q <= SEND_ID;
          end
        end
        default: begin
          if (emit) begin
            wr_q    <= 1'b1;
            dout_q  <= char_d;
            state_q <= state_d;
            if (state_q == SEND_BITS && cnt_q != '0) begin
              cnt_q <= cnt_q - CW'(1);
            end
          end else begin
            wr_q <= 1'b0;
            // Leave only once the LF strobe is out.
            if (state_q == SEND_LF && lf_done) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign ack               = ack_q;
  assign busy              = busy_q;
  assign uart_data_out     = dout_q;
  assign uart_buffer_write = wr_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench: N=4/M=8 and N=12/M=4 instances
// checked against hand-built character frames.
module tb_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] data_in;
  logic [3:0]  ack;
  logic        busy;
  logic [7:0]  dout;
  logic        wr;
  logic        full;

  logic [11:0] req2;
  logic [47:0] data2;
  logic [11:0] ack2;
  logic        busy2;
  logic [7:0]  dout2;
  logic        wr2;
  logic        full2;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  logic [7:0] cap_q[$];
  int         cap_cyc[$];
  logic [3:0] ack_log[$];
  logic [7:0] cap2_q[$];
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_scheduler #(.N(4), .M(8)) dut (
    .clk               (clk),
    .reset             (reset),
    .req               (req),
    .data_in           (data_in),
    .ack               (ack),
    .busy              (busy),
    .uart_data_out     (dout),
    .uart_buffer_write (wr),
    .uart_buffer_full  (full)
  );

  uart_tx_scheduler #(.N(12), .M(4)) dut2 (
    .clk               (clk),
    .reset             (reset),
    .req               (req2),
    .data_in           (data2),
    .ack               (ack2),
    .busy              (busy2),
    .uart_data_out     (dout2),
    .uart_buffer_write (wr2),
    .uart_buffer_full  (full2)
  );

  always @(negedge clk) begin
    if (wr) begin
      cap_q.push_back(dout);
      cap_cyc.push_back(cyc);
    end
    if (ack != 4'b0) ack_log.push_back(ack);
    if (wr2) cap2_q.push_back(dout2);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    cap_q.delete();
    cap_cyc.delete();
    ack_log.delete();
    exp_q.delete();
  endtask

  function automatic void push_frame(
    input int ch, input logic [31:0] w, input int m
  );
    exp_q.push_back(ch < 10 ? 8'(48 + ch) : 8'(55 + ch));
    exp_q.push_back(8'h3A);
    for (int b = m - 1; b >= 0; b--) begin
      exp_q.push_back(w[b] ? 8'h31 : 8'h30);
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  task automatic wait_idle(input int bound, output int fall);
    int n = 0;
    do begin
      tick();
      n++;
    end while (busy && n < bound);
    fall = cyc;
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL idle_timeout busy=%b want 0", busy);
    end
  endtask

  task automatic wait_caps(input int cnt, input int bound);
    int n = 0;
    while (cap_q.size() < cnt && n < bound) begin
      tick();
      n++;
    end
    checks++;
    if (cap_q.size() < cnt) begin
      errors++;
      $display("FAIL caps_timeout got=%0d want=%0d",
               cap_q.size(), cnt);
    end
  endtask

  task automatic serve(input int bound);
    int n = 0;
    do begin
      tick();
      req = req & ~ack;
      n++;
    end while ((req != 4'b0 || busy) && n < bound);
    checks++;
    if (req != 4'b0 || busy) begin
      errors++;
      $display("FAIL serve_timeout req=%b busy=%b", req, busy);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b1;
    tick();
    checks++;
    if (ack !== 4'b0) begin
      errors++;
      $display("FAIL rst_ack got=%b want=0", ack);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy got=%b want=0", busy);
    end
    checks++;
    if (wr !== 1'b0) begin
      errors++;
      $display("FAIL rst_wr got=%b want=0", wr);
    end
    checks++;
    if (dout !== 8'h00) begin
      errors++;
      $display("FAIL rst_dout got=%h want=00", dout);
    end
    checks++;
    if (busy2 !== 1'b0 || ack2 !== 12'h0) begin
      errors++;
      $display("FAIL rst_dut2 busy=%b ack=%h want 0",
               busy2, ack2);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [7:0] e[12] = '{8'h30, 8'h3A, 8'h31, 8'h30,
                          8'h31, 8'h30, 8'h30, 8'h31,
                          8'h30, 8'h31, 8'h0D, 8'h0A};
    int c0, f;
    clear_logs();
    data_in[7:0] = 8'hA5;
    req = 4'b0001;
    c0 = cyc;
    tick();
    checks++;
    if (ack !== 4'b0001) begin
      errors++;
      $display("FAIL single_ack got=%b want=0001", ack);
    end
    req = 4'b0;
    wait_idle(100, f);
    checks++;
    if (cap_q.size() != 12) begin
      errors++;
      $display("FAIL single_len got=%0d want=12",
               cap_q.size());
    end
    for (int i = 0; i < 12 && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== e[i]) begin
        errors++;
        $display("FAIL single_char[%0d] got=%h want=%h",
                 i, cap_q[i], e[i]);
      end
      checks++;
      if (cap_cyc[i] != c0 + 2 + 2 * i) begin
        errors++;
        $display("FAIL single_slot[%0d] got=%0d want=%0d",
                 i, cap_cyc[i] - c0, 2 + 2 * i);
      end
    end
    checks++;
    if (f != c0 + 25) begin
      errors++;
      $display("FAIL single_busy_fall got=%0d want=25",
               f - c0);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    clear_logs();
    data_in = 32'h44_33_22_11;
    req = 4'b1111;
    serve(400);
    for (int k = 0; k < 4; k++) begin
      push_frame(k, 32'(8'h11 * (k + 1)), 8);
    end
    data_in = 32'h00_F0_00_0F;
    req = 4'b0101;
    serve(200);
    push_frame(0, 32'h0F, 8);
    push_frame(2, 32'hF0, 8);
    checks++;
    if (ack_log.size() != 6) begin
      errors++;
      $display("FAIL rr_acks got=%0d want=6",
               ack_log.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (ack_log[k] !== 4'(1 << k)) begin
          errors++;
          $display("FAIL rr_order[%0d] got=%b want=%b",
                   k, ack_log[k], 4'(1 << k));
        end
      end
      checks++;
      if (ack_log[4] !== 4'b0001 ||
          ack_log[5] !== 4'b0100) begin
        errors++;
        $display("FAIL rr_wrap got=%b,%b want=0001,0100",
                 ack_log[4], ack_log[5]);
      end
    end
    checks++;
    if (cap_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rr_len got=%0d want=%0d",
               cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rr_char[%0d] got=%h want=%h",
                 i, cap_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_full_stall();
    int f, g;
    clear_logs();
    data_in[15:8] = 8'h3C;
    req = 4'b0010;
    tick();
    req = 4'b0;
    wait_caps(4, 50);
    full = 1'b1;
    repeat (10) tick();
    checks++;
    if (cap_q.size() != 4) begin
      errors++;
      $display("FAIL full_hold got=%0d want=4",
               cap_q.size());
    end
    full = 1'b0;
    f = cyc;
    wait_idle(100, g);
    push_frame(1, 32'h3C, 8);
    checks++;
    if (cap_q.size() != 12) begin
      errors++;
      $display("FAIL full_len got=%0d want=12",
               cap_q.size());
    end
    for (int i = 0; i < 12 && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL full_char[%0d] got=%h want=%h",
                 i, cap_q[i], exp_q[i]);
      end
    end
    checks++;
    if (cap_cyc.size() < 5 || cap_cyc[4] != f + 1) begin
      errors++;
      $display("FAIL full_resume got=%0d want=1",
               cap_cyc.size() < 5 ? -1 : cap_cyc[4] - f);
    end
  endtask

  task automatic test_reset_mid();
    int f;
    clear_logs();
    data_in[15:8] = 8'h55;
    req = 4'b0010;
    tick();
    req = 4'b0;
    wait_caps(5, 50);
    reset = 1'b1;
    tick();
    checks++;
    if (ack !== 4'b0 || busy !== 1'b0 ||
        wr !== 1'b0 || dout !== 8'h00) begin
      errors++;
      $display("FAIL midrst got=%b/%b/%b/%h want 0/0/0/00",
               ack, busy, wr, dout);
    end
    reset = 1'b0;
    clear_logs();
    data_in[23:16] = 8'hFF;
    req = 4'b0100;
    tick();
    checks++;
    if (ack !== 4'b0100) begin
      errors++;
      $display("FAIL midrst_ack got=%b want=0100", ack);
    end
    req = 4'b0;
    wait_idle(100, f);
    push_frame(2, 32'hFF, 8);
    checks++;
    if (cap_q.size() != 12) begin
      errors++;
      $display("FAIL midrst_len got=%0d want=12",
               cap_q.size());
    end
    for (int i = 0; i < 12 && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL midrst_char[%0d] got=%h want=%h",
                 i, cap_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int a3 = -1;
    int lows = 0;
    int n = 0;
    int f;
    clear_logs();
    data_in[15:8]  = 8'h81;
    data_in[31:24] = 8'h7E;
    req = 4'b0010;
    tick();
    req = 4'b0;
    wait_caps(3, 50);
    req = 4'b1000;
    while (a3 < 0 && n < 200) begin
      tick();
      n++;
      if (ack[3]) begin
        a3 = cyc;
        req = 4'b0;
      end else if (!busy) begin
        lows++;
      end
    end
    wait_idle(100, f);
    checks++;
    if (a3 < 0 || cap_cyc.size() < 12 ||
        a3 != cap_cyc[11] + 2) begin
      errors++;
      $display("FAIL b2b_ack3 got=%0d want=LF+2",
               (a3 < 0 || cap_cyc.size() < 12) ?
               -1 : a3 - cap_cyc[11]);
    end
    checks++;
    if (lows != 1) begin
      errors++;
      $display("FAIL b2b_gap got=%0d want=1", lows);
    end
    push_frame(1, 32'h81, 8);
    push_frame(3, 32'h7E, 8);
    checks++;
    if (cap_q.size() != 24) begin
      errors++;
      $display("FAIL b2b_len got=%0d want=24",
               cap_q.size());
    end
    for (int i = 0; i < 24 && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_char[%0d] got=%h want=%h",
                 i, cap_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_n12();
    logic [7:0] e[8] = '{8'h42, 8'h3A, 8'h30, 8'h30,
                         8'h30, 8'h30, 8'h0D, 8'h0A};
    int n = 0;
    cap2_q.delete();
    data2[47:44] = 4'h0;
    req2 = 12'h800;
    tick();
    checks++;
    if (ack2 !== 12'h800) begin
      errors++;
      $display("FAIL n12_ack got=%h want=800", ack2);
    end
    req2 = 12'h0;
    while (busy2 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (busy2 || cap2_q.size() != 8) begin
      errors++;
      $display("FAIL n12_len got=%0d want=8",
               cap2_q.size());
    end
    for (int i = 0; i < 8 && i < cap2_q.size(); i++) begin
      checks++;
      if (cap2_q[i] !== e[i]) begin
        errors++;
        $display("FAIL n12_char[%0d] got=%h want=%h",
                 i, cap2_q[i], e[i]);
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    req     = '0;
    data_in = '0;
    full    = 1'b0;
    req2    = '0;
    data2   = 48'h0123_4567_89AB;
    full2   = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_reset_mid();
    test_back_to_back();
    test_n12();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Shares one uart_tx6 transmitter between N requesters that each need to report an M-bit result, e.g. the outputs of several perceptron neurons. The block picks requesters round-robin and serializes each word as one ASCII text line: channel digit, colon, M binary digits MSB first, CR, LF. It writes characters into the UART FIFO with single-cycle write strobes and never overflows the FIFO. It sits between the perceptron datapath and uart_tx6, clocked on the same clock as the UART.

## Interface
- N, 4, number of requesters, 1..16
- M, 8, bits per reported word, 1..32
- clk  in  1  system clock, same clock as uart_tx6 clk
- reset  in  1  synchronous, active-high
- req  in  N  per-channel request level, held until acked
- data_in  in  N*M  flattened words; channel k occupies bits [k*M +: M]
- ack  out  N  one-cycle pulse: word of that channel captured
- busy  out  1  high whenever state is not IDLE
- uart_data_out  out  8  character to uart_tx6 data_in
- uart_buffer_write  out  1  one-cycle write strobe to uart_tx6 buffer_write
- uart_buffer_full  in  1  from uart_tx6 buffer_full

## Operation
- States: IDLE, SEND_ID, SEND_COLON, SEND_BITS, SEND_CR, SEND_LF.
- IDLE: if any req bit is high, the arbiter selects channel g. Priority starts at ptr and wraps from N-1 to 0. At the clock edge the block:
  - latches data_in[g] into the shift register;
  - sets ack[g]=1 for exactly one cycle;
  - sets ptr = (g+1) mod N;
  - moves to SEND_ID.
- The requester must drop req, or present a new word, in the cycle after ack. req and data_in are sampled only in IDLE.
- Character emission rule, applied in every SEND_* state at each edge:
  - if uart_buffer_full==0 and uart_buffer_write==0 (no write in the current cycle): uart_buffer_write<=1, uart_data_out<=char, then advance;
  - otherwise: uart_buffer_write<=0, uart_data_out held, state held.
  - The one-cycle gap covers the one-cycle lag of buffer_full after a FIFO write, so the FIFO never overflows.
- Characters:
  - SEND_ID: hex digit of g. 0..9 map to 0x30+g; 10..15 map to 0x41+g-10.
  - SEND_COLON: 0x3A.
  - SEND_BITS: M characters, MSB first; 0x30 for '0', 0x31 for '1'. A bit counter runs from M-1 down to 0.
  - SEND_CR: 0x0D.
  - SEND_LF: 0x0A, then go to IDLE.
- Frame length is M+4 characters.

## Timing
- Reset values: ack=0, busy=0, uart_buffer_write=0, uart_data_out=0x00, state=IDLE, ptr=0, bit counter=0.
- Reset mid-frame:
  - abandons the frame at the next edge;
  - does not clear the FIFO, so any characters already written stay in it;
  - after reset, channel 0 has highest priority.
- Latency with FIFO never full:
  - req seen in IDLE at cycle 0;
  - ack high in cycle 1;
  - first write strobe in cycle 2;
  - further strobes in cycles 4, 6, ..., 2(M+4);
  - busy falls in the cycle after the last strobe.
- A req that arrives mid-frame is not acked until the frame's LF has been written.
- Simultaneous requests are served strictly in round-robin order starting at ptr. No channel waits more than N-1 frames.
- uart_buffer_full high holds the current character, with no duplicate and no skip. Emission resumes in the cycle after full falls, provided no write occurred in the previous cycle.
- A req that drops before ack is simply not served.
- ack, busy and uart_* outputs are all registered.

## Structure
- Shared package uart_sched_pkg:
  - state enum;
  - character constants CHAR_ZERO=0x30, CHAR_ONE=0x31, CHAR_COLON=0x3A, CHAR_CR=0x0D, CHAR_LF=0x0A;
  - function hex_digit(4-bit) returning an 8-bit ASCII code.
- Sub-module rr_arbiter #(N):
  - inputs: req, ptr;
  - outputs: one-hot grant, grant index, any;
  - combinational with wrap-around priority.
- ptr, the FSM, the shift register and the output registers live in uart_tx_scheduler.

## Test plan
- N=4, M=8: ch0 req with 0xA5, full=0.
  - Required: ack[0] in cycle 1.
  - Required: 12 strobes on alternate cycles carrying 0x30 0x3A 0x31 0x30 0x31 0x30 0x30 0x31 0x30 0x31 0x0D 0x0A.
- All four req high at once with distinct words. Required: frames for ch0, ch1, ch2, ch3 in that order. A further ch0+ch2 request pair then serves ch0 first (ptr wrapped to 0).
- full forced high for 10 cycles after the 4th character of a frame.
  - Required: no strobes during those cycles.
  - Required: the 5th character is emitted once after full falls, and the frame completes with 12 characters total.
- reset pulsed during SEND_BITS.
  - Required: outputs match the reset values in the next cycle.
  - Required: a following ch2 request with 0xFF gives 0x32 0x3A, eight 0x31, 0x0D 0x0A.
- ch3 raises req while the ch1 frame is in progress. Required: ack[3] only after the LF strobe of ch1; busy low for exactly one cycle between the two frames.
- N=12, M=4: ch11 with 0x0. Required: 0x42 0x3A 0x30 0x30 0x30 0x30 0x0D 0x0A.
